// File: rtl/data_mem_responder.sv
// Load/store memory responder: one outstanding request, programmable response wait,
// range/alignment error reporting, byte-lane stores into a word array.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_rdata_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     offs_c;
    logic [AW-1:0]   idx_c;
    logic            err_c;
    logic            accept_c;
    logic            ld_we_c;
    logic            ld_err_c;
    logic [AW-1:0]   ld_idx_c;
    logic [31:0]     rdata_c;

    // Address decode: unsigned offset so addresses below the base wrap and fail the range test.
    assign offs_c   = req_addr - BASE_ADDR;
    assign idx_c    = offs_c[AW+1:2];
    assign err_c    = (req_addr[1:0] != 2'b00) || ({2'b00, offs_c[31:2]} >= DEPTH_WORDS);
    assign accept_c = req_valid && req_ready_q;

    // Response data source: live request when going straight from IDLE, captured request otherwise.
    always_comb begin
        ld_we_c  = we_q;
        ld_err_c = err_q;
        ld_idx_c = idx_q;
        if (state_q == IDLE) begin
            ld_we_c  = req_we;
            ld_err_c = err_c;
            ld_idx_c = idx_c;
        end
        rdata_c = (ld_we_c || ld_err_c) ? 32'h0 : mem_q[ld_idx_c];
    end

    // Stores commit on the accept edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (accept_c && req_we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem_q[idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        we_q        <= req_we;
                        err_q       <= err_c;
                        idx_q       <= idx_c;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ld_err_c;
                            rsp_rdata_q <= rdata_c;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ld_err_c;
                        rsp_rdata_q <= rdata_c;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a LATENCY=2 responder under directed and random traffic, plus a
// LATENCY=0 responder with a non-zero base address streamed back-to-back.
module tb_data_mem_responder;
    localparam int unsigned LAT_A  = 2;
    localparam int unsigned DEP_A  = 1024;
    localparam int unsigned DEP_B  = 64;
    localparam logic [31:0] BASE_B = 32'h100;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
    logic        a_rsp_ready = 1'b0;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;

    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
    logic        b_rsp_ready = 1'b1;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    data_mem_responder #(.DEPTH_WORDS(DEP_A), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEP_B), .LATENCY(0), .BASE_ADDR(BASE_B)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    exp_t        aq[$];
    exp_t        bq[$];
    logic [31:0] amem [DEP_A];
    logic [31:0] bmem [DEP_B];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          a_last_hs = -1;
    bit          a_seen = 1'b0;
    logic [31:0] a_hd;
    logic        a_he;
    int          b_prev = -1;
    bit          b_b2b = 1'b0;
    int          rdy_mode = 1;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: memory as a plain word array, error from address arithmetic.
    function automatic exp_t model(input bit is_b, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        logic [31:0] base;
        int unsigned depth;
        int unsigned w;
        logic [31:0] word;
        base  = is_b ? BASE_B : 32'h0;
        depth = is_b ? DEP_B : DEP_A;
        e.err   = (addr % 4 != 0) || (addr < base) || ((addr - base) / 4 >= depth);
        e.rdata = 32'h0;
        e.acc   = cyc;
        if (!e.err) begin
            w    = (addr - base) / 4;
            word = is_b ? bmem[w] : amem[w];
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                if (is_b) bmem[w] = word;
                else amem[w] = word;
            end else begin
                e.rdata = word;
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       a_rsp_ready = 1'b0;
            1:       a_rsp_ready = 1'b1;
            default: a_rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor / scoreboard for responder A
    always @(negedge clk) begin
        if (!rst) begin
            a_seen = 1'b0;
        end else begin
            if (a_rsp_valid) begin
                chk(!a_req_ready, "a_req_ready_in_resp", 32'(a_req_ready), 32'h0);
                if (aq.size() == 0) begin
                    chk(1'b0, "a_unexpected_rsp", a_rsp_rdata, 32'h0);
                end else begin
                    if (!a_seen) begin
                        a_seen = 1'b1;
                        a_hd   = a_rsp_rdata;
                        a_he   = a_rsp_err;
                        chk(cyc - aq[0].acc == int'(LAT_A) + 1, "a_latency",
                            32'(cyc - aq[0].acc), 32'(LAT_A + 1));
                    end else begin
                        chk(a_rsp_rdata === a_hd && a_rsp_err === a_he, "a_stable", a_rsp_rdata, a_hd);
                    end
                    if (a_rsp_ready) begin
                        chk(a_rsp_rdata === aq[0].rdata, "a_rdata", a_rsp_rdata, aq[0].rdata);
                        chk(a_rsp_err === aq[0].err, "a_err", 32'(a_rsp_err), 32'(aq[0].err));
                        void'(aq.pop_front());
                        a_seen    = 1'b0;
                        a_last_hs = cyc;
                    end
                end
            end else begin
                chk(a_rsp_rdata === 32'h0 && a_rsp_err === 1'b0, "a_idle_outputs", a_rsp_rdata, 32'h0);
            end
            if (a_req_valid && a_req_ready)
                aq.push_back(model(1'b0, a_req_we, a_req_addr, a_req_wdata, a_req_be));
        end
    end

    // Monitor / scoreboard for responder B (rsp_ready tied high)
    always @(negedge clk) begin
        if (rst) begin
            if (b_rsp_valid) begin
                chk(!b_req_ready, "b_req_ready_in_resp", 32'(b_req_ready), 32'h0);
                if (bq.size() == 0) begin
                    chk(1'b0, "b_unexpected_rsp", b_rsp_rdata, 32'h0);
                end else begin
                    chk(cyc - bq[0].acc == 1, "b_latency", 32'(cyc - bq[0].acc), 32'h1);
                    chk(b_rsp_rdata === bq[0].rdata, "b_rdata", b_rsp_rdata, bq[0].rdata);
                    chk(b_rsp_err === bq[0].err, "b_err", 32'(b_rsp_err), 32'(bq[0].err));
                    void'(bq.pop_front());
                end
            end
            if (b_req_valid && b_req_ready) begin
                if (b_b2b && b_prev >= 0)
                    chk(cyc - b_prev == 2, "b_spacing", 32'(cyc - b_prev), 32'h2);
                b_prev = cyc;
                bq.push_back(model(1'b1, b_req_we, b_req_addr, b_req_wdata, b_req_be));
            end
        end
    end

    task automatic a_send(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int n = 0;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
        do begin @(negedge clk); n++; end while (!a_req_ready && n < 100);
        if (!a_req_ready) chk(1'b0, "a_accept_timeout", addr, 32'h0);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic b_send(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int n = 0;
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
        do begin @(negedge clk); n++; end while (!b_req_ready && n < 50);
        if (!b_req_ready) chk(1'b0, "b_accept_timeout", addr, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic a_drain();
        int n = 0;
        while (aq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (aq.size() != 0) chk(1'b0, "a_drain_timeout", 32'(aq.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        logic [31:0] addr;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk(!a_req_ready && !a_rsp_valid, "a_reset_handshake", {a_req_ready, a_rsp_valid}, 32'h0);
            chk(a_rsp_rdata === 32'h0 && a_rsp_err === 1'b0, "a_reset_data", a_rsp_rdata, 32'h0);
            chk(!b_req_ready && !b_rsp_valid, "b_reset_handshake", {b_req_ready, b_rsp_valid}, 32'h0);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk(a_req_ready === 1'b1, "a_ready_after_reset", 32'(a_req_ready), 32'h1);
        chk(b_req_ready === 1'b1, "b_ready_after_reset", 32'(b_req_ready), 32'h1);

        // Prefill words used by loads, then the directed store/load sequence
        for (int w = 0; w < 16; w++) a_send(1'b1, 32'(w * 4), $urandom, 4'hF);
        a_send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        a_send(1'b0, 32'h10, 32'h0, 4'h0);
        a_send(1'b1, 32'h10, 32'h00000055, 4'b0001);
        a_send(1'b0, 32'h10, 32'h0, 4'h0);
        a_send(1'b0, 32'h12, 32'h0, 4'h0);
        a_send(1'b1, 32'h1000, 32'h12345678, 4'hF);
        a_send(1'b0, 32'h0, 32'h0, 4'h0);
        a_send(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000);
        a_send(1'b0, 32'h8, 32'h0, 4'h0);
        a_drain();

        // Stalled response with a queued request behind it
        @(negedge clk); rdy_mode = 0;
        @(posedge clk); #1;
        a_send(1'b0, 32'h10, 32'h0, 4'h0);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h14; a_req_wdata = '0; a_req_be = '0;
        n = 0;
        while (!a_rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!a_rsp_valid) chk(1'b0, "a_stall_rsp_timeout", 32'h0, 32'h1);
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_req_ready && n < 20);
        chk(a_req_ready && cyc == a_last_hs + 1, "a_accept_after_hs", 32'(cyc - a_last_hs), 32'h1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_drain();

        // Reset while a committed store waits for its response
        @(posedge clk); #1;
        a_send(1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        #2 rst = 1'b0;
        aq.delete();
        #1;
        chk(a_rsp_valid === 1'b0, "a_rsp_valid_in_reset", 32'(a_rsp_valid), 32'h0);
        chk(a_req_ready === 1'b0, "a_req_ready_in_reset", 32'(a_req_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        chk(a_req_ready === 1'b1, "a_ready_after_release", 32'(a_req_ready), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        a_send(1'b0, 32'h14, 32'h0, 4'h0);
        a_drain();

        // Random traffic with random response back-pressure
        @(negedge clk); rdy_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 1) addr = 32'h1000 + ($urandom & 32'h7FFF_FFFC);
            else             addr = 32'($urandom_range(0, 15)) * 4;
            a_send(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom));
        end
        a_drain();

        // Zero-latency responder streamed back-to-back
        b_b2b = 1'b1; b_prev = -1;
        for (int w = 0; w < 16; w++) b_send(1'b1, BASE_B + 32'(w * 4), $urandom, 4'hF);
        for (int i = 0; i < 16; i++) b_send(1'b0, BASE_B + 32'($urandom_range(0, 15)) * 4, 32'h0, 4'h0);
        b_send(1'b0, 32'hFC, 32'h0, 4'h0);
        b_send(1'b1, BASE_B + 32'(DEP_B * 4), 32'hA5A5A5A5, 4'hF);
        b_send(1'b0, BASE_B + 32'h1, 32'h0, 4'h0);
        b_send(1'b1, BASE_B + 32'h4, 32'h0000BB00, 4'b0010);
        b_send(1'b0, BASE_B + 32'h4, 32'h0, 4'h0);
        b_req_valid = 1'b0;
        b_b2b = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (bq.size() != 0) chk(1'b0, "b_drain_timeout", 32'(bq.size()), 32'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
